// File: rtl/spi_cmd_decoder_pkg.sv
// Shared constants and types for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'h01;
  localparam logic [7:0] OP_RD   = 8'h02;
  localparam logic [7:0] OP_GO   = 8'h03;
  localparam logic [7:0] OP_STAT = 8'h04;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam int unsigned STAT_ACTIVE_BIT = 7;
  localparam int unsigned STAT_ERR_BIT    = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_RPREF,
    ST_RDATA,
    ST_DISC
  } state_t;

  function automatic logic [7:0] stat_byte(input logic active, input logic err);
    logic [7:0] b;
    b = '0;
    b[STAT_ACTIVE_BIT] = active;
    b[STAT_ERR_BIT]    = err;
    return b;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// SPI-byte side and BRAM com-port side of the command decoder.
interface spi_cmd_decoder_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              ss;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic [ADDR_W-1:0] bram_addr;
  logic [1:0]        bram_chan;
  logic              bram_we;
  logic [7:0]        bram_wdata;
  logic [7:0]        bram_rdata;
  logic              pdi_active;
  logic              pdi_start;
  logic              err;

  modport slave (
    input  ss, rx_dv, rx_byte, bram_rdata, pdi_active,
    output tx_byte, bram_addr, bram_chan, bram_we, bram_wdata, pdi_start, err
  );

  modport master (
    output ss, rx_dv, rx_byte, bram_rdata, pdi_active,
    input  tx_byte, bram_addr, bram_chan, bram_we, bram_wdata, pdi_start, err
  );
endinterface

// File: rtl/spi_cmd_decoder_addr_gen.sv
// Pixel address register: parallel load, increment with wrap past ADDR_MAX.
module spi_addr_gen #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned ADDR_MAX = 76799
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] r_addr;

  // load has priority over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_addr <= '0;
    else if (i_load)
      r_addr <= i_addr;
    else if (i_inc)
      r_addr <= (r_addr >= ADDR_W'(ADDR_MAX)) ? '0 : r_addr + ADDR_W'(1);
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames rx bytes into WR/RD/GO/STAT commands and
// drives the BRAM com port. Optional inter-byte timeout: SPI_CMD_TIMEOUT_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned ADDR_MAX    = 76799,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input logic               clk,
  input logic               rst,
  spi_cmd_decoder_if.slave  bus
);

  state_t      r_state, w_state_n;
  logic [2:0]  r_hcnt,  w_hcnt_n;
  logic        r_is_rd, w_is_rd_n;
  logic [1:0]  r_chan,  w_chan_n;
  logic        r_a16,   w_a16_n;
  logic [7:0]  r_ahi,   w_ahi_n;
  logic [7:0]  r_lenhi, w_lenhi_n;
  logic [15:0] r_len,   w_len_n;
  logic [1:0]  r_lat,   w_lat_n;
  logic [7:0]  r_tx,    w_tx_n;
  logic        r_we,    w_we_n;
  logic [7:0]  r_wdata, w_wdata_n;
  logic        r_start, w_start_n;
  logic        r_err,   w_err_n;

  logic              w_byte;
  logic              w_load;
  logic              w_inc;
  logic [ADDR_W-1:0] w_addr;

  // a byte that arrives together with ss high is dropped
  assign w_byte = bus.rx_dv & ~bus.ss;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to;

  // cycles since the last accepted byte while a frame is open
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_to <= '0;
    else if (w_byte || r_state == ST_IDLE)
      r_to <= '0;
    else
      r_to <= r_to + TO_W'(1);
  end
`endif

  spi_addr_gen #(
    .ADDR_W   (ADDR_W),
    .ADDR_MAX (ADDR_MAX)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_addr (ADDR_W'({r_a16, r_ahi, bus.rx_byte})),
    .i_inc  (w_inc),
    .o_addr (w_addr)
  );

  // next-state and next-output decode
  always_comb begin
    w_state_n = r_state;
    w_hcnt_n  = r_hcnt;
    w_is_rd_n = r_is_rd;
    w_chan_n  = r_chan;
    w_a16_n   = r_a16;
    w_ahi_n   = r_ahi;
    w_lenhi_n = r_lenhi;
    w_len_n   = r_len;
    w_lat_n   = r_lat;
    w_tx_n    = r_tx;
    w_we_n    = 1'b0;
    w_wdata_n = r_wdata;
    w_start_n = 1'b0;
    w_err_n   = r_err;
    w_load    = 1'b0;
    w_inc     = r_we;   // step past each address once its write has gone out

    if (r_state != ST_IDLE && bus.ss) begin
      w_state_n = ST_IDLE;
      w_tx_n    = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_byte) begin
          w_tx_n = '0;
          case (bus.rx_byte)
            OP_WR, OP_RD: begin
              w_state_n = ST_HDR;
              w_hcnt_n  = '0;
              w_is_rd_n = (bus.rx_byte == OP_RD);
            end
            OP_GO: begin
              if (bus.pdi_active) w_err_n   = 1'b1;
              else                w_start_n = 1'b1;
            end
            OP_STAT: begin
              w_tx_n  = stat_byte(bus.pdi_active, r_err);
              w_err_n = 1'b0;
            end
            default: w_err_n = 1'b1;
          endcase
        end
        ST_HDR: if (w_byte) begin
          w_hcnt_n = r_hcnt + 3'd1;
          case (r_hcnt)
            3'd0: begin
              w_chan_n = bus.rx_byte[7:6];
              w_a16_n  = bus.rx_byte[0];
            end
            3'd1: w_ahi_n   = bus.rx_byte;
            3'd2: w_load    = 1'b1;
            3'd3: w_lenhi_n = bus.rx_byte;
            default: begin
              w_len_n = {r_lenhi, bus.rx_byte};
              w_lat_n = '0;
              if (bus.pdi_active) w_err_n = 1'b1;
              if (w_len_n == 16'd0)    w_state_n = ST_IDLE;
              else if (bus.pdi_active) w_state_n = ST_DISC;
              else if (r_is_rd)        w_state_n = ST_RPREF;
              else                     w_state_n = ST_WDATA;
            end
          endcase
        end
        ST_WDATA: if (w_byte) begin
          w_wdata_n = bus.rx_byte;
          w_we_n    = 1'b1;
          w_len_n   = r_len - 16'd1;
          if (r_len == 16'd1) w_state_n = ST_IDLE;
        end
        ST_RPREF: begin
          if (r_lat == 2'(RD_LAT)) begin
            w_tx_n    = bus.bram_rdata;
            w_state_n = ST_RDATA;
          end else begin
            w_lat_n = r_lat + 2'd1;
          end
        end
        ST_RDATA: if (w_byte) begin
          if (r_len == 16'd1) begin
            w_state_n = ST_IDLE;
            w_tx_n    = '0;
          end else begin
            w_len_n   = r_len - 16'd1;
            w_inc     = 1'b1;
            w_lat_n   = '0;
            w_state_n = ST_RPREF;
          end
        end
        ST_DISC: if (w_byte) begin
          w_len_n = r_len - 16'd1;
          if (r_len == 16'd1) w_state_n = ST_IDLE;
        end
        default: w_state_n = ST_IDLE;
      endcase
`ifdef SPI_CMD_TIMEOUT_EN
      if (r_state != ST_IDLE && !w_byte && r_to == TO_W'(TIMEOUT_CYC - 1)) begin
        w_state_n = ST_IDLE;
        w_err_n   = 1'b1;
        w_tx_n    = '0;
      end
`endif
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_is_rd <= 1'b0;
      r_chan  <= '0;
      r_a16   <= 1'b0;
      r_ahi   <= '0;
      r_lenhi <= '0;
      r_len   <= '0;
      r_lat   <= '0;
      r_tx    <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_hcnt  <= w_hcnt_n;
      r_is_rd <= w_is_rd_n;
      r_chan  <= w_chan_n;
      r_a16   <= w_a16_n;
      r_ahi   <= w_ahi_n;
      r_lenhi <= w_lenhi_n;
      r_len   <= w_len_n;
      r_lat   <= w_lat_n;
      r_tx    <= w_tx_n;
      r_we    <= w_we_n;
      r_wdata <= w_wdata_n;
      r_start <= w_start_n;
      r_err   <= w_err_n;
    end
  end

  assign bus.tx_byte    = r_tx;
  assign bus.bram_addr  = w_addr;
  assign bus.bram_chan  = r_chan;
  assign bus.bram_we    = r_we;
  assign bus.bram_wdata = r_wdata;
  assign bus.pdi_start  = r_start;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder with a RD_LAT=1 BRAM model.
module tb_spi_cmd_decoder;

  localparam int unsigned ADDR_W = 17;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  logic [7:0] mem [0:76799];
  logic [1:0]        log_chan [0:63];
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [7:0]        log_data [0:63];
  int   wr_n;
  int   st_n;

  spi_cmd_decoder_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_decoder #(
    .ADDR_W      (ADDR_W),
    .ADDR_MAX    (76799),
    .RD_LAT      (1),
`ifdef SPI_CMD_TIMEOUT_EN
    .TIMEOUT_CYC (100)
`else
    .TIMEOUT_CYC (50000)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model plus write / start-pulse logging
  always @(posedge clk) begin
    if (bus.bram_we) begin
      mem[bus.bram_addr] <= bus.bram_wdata;
      log_chan[wr_n] = bus.bram_chan;
      log_addr[wr_n] = bus.bram_addr;
      log_data[wr_n] = bus.bram_wdata;
      wr_n = wr_n + 1;
    end
    if (bus.pdi_start) st_n = st_n + 1;
    bus.bram_rdata <= mem[bus.bram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_byte = b;
    bus.rx_dv   = 1'b1;
    @(negedge clk);
    bus.rx_dv   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [1:0] ch,
                          input logic [16:0] a, input logic [15:0] len);
    send_byte(op);
    send_byte({ch, 5'b0, a[16]});
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; wr_n = 0; st_n = 0;
    bus.ss = 1'b0; bus.rx_dv = 1'b0; bus.rx_byte = 8'h00; bus.pdi_active = 1'b0;
    mem[76799] = 8'h5A;
    mem[0]     = 8'hA5;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",    32'(bus.tx_byte), 32'h0);
    check("rst_addr",  32'(bus.bram_addr), 32'h0);
    check("rst_ctl",   32'({bus.bram_chan, bus.bram_we, bus.pdi_start, bus.err}), 32'h0);
    check("rst_wdata", 32'(bus.bram_wdata), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // WR ch1 @0x10 LEN 3
    send_hdr(8'h01, 2'd1, 17'h00010, 16'd3);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("wr_count", 32'(wr_n), 32'd3);
    check("wr0", {log_chan[0], 5'b0, log_addr[0], log_data[0]}, {2'd1, 5'b0, 17'h10, 8'hAA});
    check("wr1", {log_chan[1], 5'b0, log_addr[1], log_data[1]}, {2'd1, 5'b0, 17'h11, 8'hBB});
    check("wr2", {log_chan[2], 5'b0, log_addr[2], log_data[2]}, {2'd1, 5'b0, 17'h12, 8'hCC});
    check("wr_err", 32'(bus.err), 32'h0);

    // RD ch2 @76799 LEN 2, wraps to 0
    send_hdr(8'h02, 2'd2, 17'h12BFF, 16'd2);
    check("rd_tx0",  32'(bus.tx_byte), 32'h5A);
    check("rd_chan", 32'(bus.bram_chan), 32'd2);
    send_byte(8'h00);
    check("rd_wrap_addr", 32'(bus.bram_addr), 32'h0);
    check("rd_tx1", 32'(bus.tx_byte), 32'hA5);
    send_byte(8'h00);
    check("rd_tx_idle", 32'(bus.tx_byte), 32'h0);
    check("rd_no_wr", 32'(wr_n), 32'd3);

    // GO idle / busy, then STAT
    send_byte(8'h03);
    check("go_pulse", 32'(st_n), 32'd1);
    check("go_err", 32'(bus.err), 32'h0);
    bus.pdi_active = 1'b1;
    send_byte(8'h03);
    check("go_busy_nopulse", 32'(st_n), 32'd1);
    check("go_busy_err", 32'(bus.err), 32'h1);
    send_byte(8'h04);
    check("stat_c0", 32'(bus.tx_byte), 32'hC0);
    check("stat_clr", 32'(bus.err), 32'h0);
    bus.pdi_active = 1'b0;

    // WR LEN 4 aborted by ss after 2 bytes
    send_hdr(8'h01, 2'd0, 17'h00100, 16'd4);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk) bus.ss = 1'b1;
    repeat (4) @(negedge clk);
    bus.ss = 1'b0;
    check("abort_count", 32'(wr_n), 32'd5);
    check("abort_wr1", {log_addr[4], log_data[4]}, {17'h101, 8'h22});
    check("abort_err", 32'(bus.err), 32'h0);
    send_hdr(8'h01, 2'd0, 17'h00200, 16'd1);
    send_byte(8'h33);
    check("post_abort_wr", {wr_n[7:0], log_addr[5], log_data[5]}, {8'd6, 17'h200, 8'h33});

    // rx_dv together with ss rise: byte dropped
    send_hdr(8'h01, 2'd0, 17'h00180, 16'd2);
    @(negedge clk);
    bus.rx_byte = 8'hEE; bus.rx_dv = 1'b1; bus.ss = 1'b1;
    @(negedge clk);
    bus.rx_dv = 1'b0;
    repeat (4) @(negedge clk);
    bus.ss = 1'b0;
    check("ss_dv_drop", 32'(wr_n), 32'd6);

    // bad opcode, then STAT
    send_byte(8'h7F);
    check("badop_err", 32'(bus.err), 32'h1);
    send_byte(8'h04);
    check("stat_40", 32'(bus.tx_byte), 32'h40);
    check("stat_40_clr", 32'(bus.err), 32'h0);

    // LEN 0: no access, next opcode accepted
    send_hdr(8'h01, 2'd1, 17'h00050, 16'd0);
    send_byte(8'h03);
    check("len0_idle", {24'(wr_n), 8'(st_n)}, {24'd6, 8'd2});

    // busy at header end: discard data
    bus.pdi_active = 1'b1;
    send_hdr(8'h01, 2'd0, 17'h00060, 16'd2);
    bus.pdi_active = 1'b0;
    send_byte(8'h44); send_byte(8'h55);
    check("disc_nowr", 32'(wr_n), 32'd6);
    check("disc_err", 32'(bus.err), 32'h1);
    send_byte(8'h04);
    check("disc_stat", 32'(bus.tx_byte), 32'h40);

`ifdef SPI_CMD_TIMEOUT_EN
    send_byte(8'h01);
    repeat (101) @(negedge clk);
    check("timeout_err", 32'(bus.err), 32'h1);
    send_byte(8'h04);
    check("timeout_idle", 32'(bus.tx_byte), 32'h40);
`endif

    // reset mid-WDATA
    send_hdr(8'h01, 2'd2, 17'h00300, 16'd3);
    send_byte(8'h66);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_addr", 32'(bus.bram_addr), 32'h0);
    check("rst_mid_out", {bus.tx_byte, bus.bram_wdata, 4'b0, bus.bram_chan, bus.bram_we, bus.err},
          32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    send_hdr(8'h01, 2'd2, 17'h00400, 16'd1);
    send_byte(8'h77);
    check("post_rst_wr", {wr_n[7:0], log_chan[7], 5'b0, log_addr[7]}, {8'd8, 2'd2, 5'b0, 17'h400});
    check("post_rst_data", 32'(log_data[7]), 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
